// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared AMO encodings, FSM states and latency for amo_unit
package riscv_pkg;

  localparam int AMO_LATENCY = 3;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_funct5_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE
  } amo_state_e;

  // Reserved encodings still return the old value but must not modify memory
  function automatic logic amo_funct5_writes(input logic [4:0] funct5);
    case (funct5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational new-value function for RV32A read-modify-write atomics
module amo_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_funct5,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_new
);

  logic w_lt_signed;
  logic w_lt_unsigned;

  assign w_lt_signed   = $signed(i_old) < $signed(i_rs2);
  assign w_lt_unsigned = i_old < i_rs2;

  always_comb begin
    o_new = i_old;
    case (i_funct5)
      AMO_ADD:  o_new = i_old + i_rs2;
      AMO_SWAP: o_new = i_rs2;
      AMO_XOR:  o_new = i_old ^ i_rs2;
      AMO_OR:   o_new = i_old | i_rs2;
      AMO_AND:  o_new = i_old & i_rs2;
      AMO_MIN:  o_new = w_lt_signed   ? i_old : i_rs2;
      AMO_MAX:  o_new = w_lt_signed   ? i_rs2 : i_old;
      AMO_MINU: o_new = w_lt_unsigned ? i_old : i_rs2;
      AMO_MAXU: o_new = w_lt_unsigned ? i_rs2 : i_old;
      default:  o_new = i_old;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// rtl/amo_unit.sv - RV32A AMO sequencer against a 1-cycle BRAM, stalls the pipeline while busy
// Optional LR/SC reservation tracking: define FROST_AMO_LR_RESERVATION_EN
module amo_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_amo_start,
  input  logic [4:0]      i_amo_funct5,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_mem_rd_data,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_rd_en,
  output logic [3:0]      o_mem_wr_en,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic            o_stall_req,
  output logic [XLEN-1:0] o_amo_result,
  output logic            o_amo_write_enable,
  output logic            o_misaligned,
  input  logic            i_lr_valid,
  input  logic            i_sc_valid,
  input  logic            i_store_snoop_valid,
  input  logic [XLEN-1:0] i_store_snoop_addr,
  output logic            o_sc_success
);

  amo_state_e      r_state;
  amo_state_e      w_next_state;
  logic [4:0]      r_funct5;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_new;
  logic            r_misaligned;
  logic [XLEN-1:0] w_alu_new;
  logic            w_start;
  logic            w_aligned;

  assign w_start   = (r_state == IDLE) & i_amo_start;
  assign w_aligned = (i_addr[1:0] == 2'b00);

  amo_alu #(.XLEN(XLEN)) u_amo_alu (
    .i_funct5 (r_funct5),
    .i_old    (i_mem_rd_data),
    .i_rs2    (r_rs2),
    .o_new    (w_alu_new)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_funct5     <= 5'd0;
      r_addr       <= '0;
      r_rs2        <= '0;
      r_old        <= '0;
      r_new        <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_start & ~w_aligned;
      if (w_start) begin
        r_funct5 <= i_amo_funct5;
        r_addr   <= i_addr;
        r_rs2    <= i_rs2_data;
      end
      if (r_state == CAPTURE) begin
        r_old <= i_mem_rd_data;
        r_new <= w_alu_new;
      end
    end
  end

  always_comb begin
    w_next_state       = r_state;
    o_mem_rd_en        = 1'b0;
    o_mem_wr_en        = 4'h0;
    o_amo_write_enable = 1'b0;
    o_stall_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_amo_start) begin
          o_stall_req = 1'b1;
          if (w_aligned) w_next_state = READ;
        end
      end
      READ: begin
        o_mem_rd_en  = 1'b1;
        o_stall_req  = 1'b1;
        w_next_state = CAPTURE;
      end
      CAPTURE: begin
        o_stall_req  = 1'b1;
        w_next_state = WRITE;
      end
      WRITE: begin
        o_stall_req        = 1'b1;
        o_amo_write_enable = 1'b1;
        o_mem_wr_en        = amo_funct5_writes(r_funct5) ? 4'hF : 4'h0;
        w_next_state       = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_mem_addr    = r_addr;
  assign o_mem_wr_data = r_new;
  assign o_amo_result  = r_old;
  assign o_misaligned  = r_misaligned;

`ifdef FROST_AMO_LR_RESERVATION_EN
  logic            r_resv_valid;
  logic [XLEN-3:0] r_resv_word;
  logic            w_resv_clear;
  logic            w_unused_snoop_low;

  assign w_resv_clear = i_sc_valid
                      | ((r_state == WRITE) & (r_addr[XLEN-1:2] == r_resv_word))
                      | (i_store_snoop_valid & (i_store_snoop_addr[XLEN-1:2] == r_resv_word));

  // A new LR takes priority over any clearing event in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resv_valid <= 1'b0;
      r_resv_word  <= '0;
    end else if (i_lr_valid) begin
      r_resv_valid <= 1'b1;
      r_resv_word  <= i_addr[XLEN-1:2];
    end else if (w_resv_clear) begin
      r_resv_valid <= 1'b0;
    end
  end

  assign o_sc_success       = r_resv_valid & (i_addr[XLEN-1:2] == r_resv_word);
  assign w_unused_snoop_low = ^i_store_snoop_addr[1:0];
`else
  logic w_unused_resv_inputs;

  // Single-hart, interrupt-free builds: SC.W always succeeds
  assign o_sc_success         = 1'b1;
  assign w_unused_resv_inputs = ^{i_lr_valid, i_sc_valid, i_store_snoop_valid, i_store_snoop_addr};
`endif

endmodule

// File: tb/tb_amo_unit.sv
// tb/tb_amo_unit.sv - scoreboard bench for amo_unit with directed AMO vectors
module tb_amo_unit;
  import riscv_pkg::*;

  typedef struct {
    bit          mis;
    int          cyc;
    logic [31:0] res;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        amo_start;
  logic [4:0]  amo_funct5;
  logic [31:0] addr;
  logic [31:0] rs2_data;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [3:0]  mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        stall_req;
  logic [31:0] amo_result;
  logic        amo_write_enable;
  logic        misaligned;
  logic        lr_valid;
  logic        sc_valid;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        sc_success;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  amo_unit #(.XLEN(32)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_amo_start         (amo_start),
    .i_amo_funct5        (amo_funct5),
    .i_addr              (addr),
    .i_rs2_data          (rs2_data),
    .i_mem_rd_data       (mem_rd_data),
    .o_mem_addr          (mem_addr),
    .o_mem_rd_en         (mem_rd_en),
    .o_mem_wr_en         (mem_wr_en),
    .o_mem_wr_data       (mem_wr_data),
    .o_stall_req         (stall_req),
    .o_amo_result        (amo_result),
    .o_amo_write_enable  (amo_write_enable),
    .o_misaligned        (misaligned),
    .i_lr_valid          (lr_valid),
    .i_sc_valid          (sc_valid),
    .i_store_snoop_valid (snoop_valid),
    .i_store_snoop_addr  (snoop_addr),
    .o_sc_success        (sc_success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wr_en[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (amo_write_enable || misaligned)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got we=%b mis=%b expected none", amo_write_enable, misaligned);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {31'd0, misaligned}, {31'd0, e.mis});
        chk("pulse_cycle", cyc, e.cyc);
        if (!e.mis) chk("amo_result", amo_result, e.res);
      end
    end
  end

  task automatic mem_set(input logic [31:0] a, input logic [31:0] d);
    pl_idx  = a[9:2];
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  task automatic run_amo(input logic [4:0] f, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] exp_res, input logic [3:0] exp_wr,
                         input logic [31:0] exp_mem, input bit mis, input bit hold);
    exp_t e;
    e.mis = mis;
    e.cyc = cyc + (mis ? 1 : AMO_LATENCY);
    e.res = exp_res;
    exp_q.push_back(e);
    amo_funct5 = f;
    addr       = a;
    rs2_data   = rs2;
    amo_start  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall", {31'd0, stall_req}, mis ? {31'd0, c == 0} : {31'd0, c < 4});
      chk("rd_en", {31'd0, mem_rd_en}, {31'd0, !mis && c == 1});
      chk("wr_en", {28'd0, mem_wr_en}, (!mis && c == AMO_LATENCY) ? {28'd0, exp_wr} : 32'd0);
      @(posedge clk); #1;
      amo_start = hold && c < 2;
      if (hold) begin
        amo_funct5 = AMO_XOR;
        rs2_data   = 32'h5A5A5A5A;
      end
    end
    chk("mem_after", mem[a[9:2]], exp_mem);
  endtask

  initial begin
    rst_n       = 1'b0;
    amo_start   = 1'b0;
    amo_funct5  = 5'd0;
    addr        = 32'd0;
    rs2_data    = 32'd0;
    lr_valid    = 1'b0;
    sc_valid    = 1'b0;
    snoop_valid = 1'b0;
    snoop_addr  = 32'd0;
    pl_en       = 1'b0;
    pl_idx      = 8'd0;
    pl_data     = 32'd0;
    mem_rd_data = 32'd0;

    @(negedge clk);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_we", {31'd0, amo_write_enable}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_wr_en", {28'd0, mem_wr_en}, 32'd0);
    chk("rst_result", amo_result, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    mem_set(32'h100, 32'd5);
    run_amo(AMO_ADD,  32'h100, 32'd7, 32'd5, 4'hF, 32'd12, 1'b0, 1'b0);
    mem_set(32'h100, 32'hFFFFFFFF);
    run_amo(AMO_MIN,  32'h100, 32'd1, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
    mem_set(32'h100, 32'hFFFFFFFF);
    run_amo(AMO_MINU, 32'h100, 32'd1, 32'hFFFFFFFF, 4'hF, 32'd1, 1'b0, 1'b0);
    mem_set(32'h100, 32'hFFFFFFFF);
    run_amo(AMO_MAX,  32'h100, 32'd1, 32'hFFFFFFFF, 4'hF, 32'd1, 1'b0, 1'b0);
    mem_set(32'h100, 32'hFFFFFFFF);
    run_amo(AMO_MAXU, 32'h100, 32'd1, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
    mem_set(32'h104, 32'h0000F0F0);
    run_amo(AMO_AND,  32'h104, 32'h0000FF00, 32'h0000F0F0, 4'hF, 32'h0000F000, 1'b0, 1'b0);
    mem_set(32'h104, 32'h0000F0F0);
    run_amo(AMO_OR,   32'h104, 32'h0000FF00, 32'h0000F0F0, 4'hF, 32'h0000FFF0, 1'b0, 1'b0);
    mem_set(32'h108, 32'h00001234);
    run_amo(AMO_SWAP, 32'h108, 32'hDEADBEEF, 32'h00001234, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
    mem_set(32'h100, 32'h00000077);
    run_amo(AMO_SWAP, 32'h102, 32'hCAFEF00D, 32'd0, 4'h0, 32'h00000077, 1'b1, 1'b0);
    mem_set(32'h10C, 32'h000000AA);
    run_amo(5'b11111, 32'h10C, 32'h00000011, 32'h000000AA, 4'h0, 32'h000000AA, 1'b0, 1'b0);

    mem_set(32'h100, 32'h00000055);
    amo_funct5 = AMO_ADD;
    addr       = 32'h100;
    rs2_data   = 32'd1;
    amo_start  = 1'b1;
    @(posedge clk); #1;
    amo_start  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stall_req}, 32'd0);
    chk("abort_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("abort_wr_en", {28'd0, mem_wr_en}, 32'd0);
    chk("abort_result", amo_result, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_wr_data", mem_wr_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_abort_wr_en", {28'd0, mem_wr_en}, 32'd0);
    end
    chk("post_abort_mem", mem[8'd64], 32'h00000055);
    @(posedge clk); #1;
    mem_set(32'h100, 32'h000000F0);
    run_amo(AMO_XOR, 32'h100, 32'h000000FF, 32'h000000F0, 4'hF, 32'h0000000F, 1'b0, 1'b0);

`ifdef FROST_AMO_LR_RESERVATION_EN
    addr = 32'h200;
    lr_valid = 1'b1;
    @(posedge clk); #1;
    lr_valid    = 1'b0;
    snoop_valid = 1'b1;
    snoop_addr  = 32'h200;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    sc_valid    = 1'b1;
    @(negedge clk);
    chk("sc_after_snoop", {31'd0, sc_success}, 32'd0);
    @(posedge clk); #1;
    sc_valid = 1'b0;
    lr_valid = 1'b1;
    @(posedge clk); #1;
    lr_valid = 1'b0;
    sc_valid = 1'b1;
    @(negedge clk);
    chk("sc_after_lr", {31'd0, sc_success}, 32'd1);
    @(posedge clk); #1;
    sc_valid = 1'b0;
`else
    addr     = 32'h200;
    sc_valid = 1'b1;
    @(negedge clk);
    chk("sc_tied", {31'd0, sc_success}, 32'd1);
    @(posedge clk); #1;
    sc_valid = 1'b0;
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amo_unit.md
Name: amo_unit

Overview:
- Executes RV32A read-modify-write atomics (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W) against the 1-cycle-latency data BRAM.
- Sits beside EX, directly upstream of the MA stage: holds the pipeline with a stall request while it runs.
- Produces the old memory value and a one-cycle write-enable pulse; MA delays that pulse and writes the value back to rd.

Parameters:
XLEN, 32, data/address width (only 32 supported)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_amo_start  in  1  EX holds a valid, unflushed AMO this cycle
i_amo_funct5  in  5  instruction funct5
i_addr  in  XLEN  rs1 value (effective address)
i_rs2_data  in  XLEN  rs2 operand
i_mem_rd_data  in  XLEN  BRAM read data, valid the cycle after o_mem_rd_en
o_mem_addr  out  XLEN  word address for the BRAM port (latched i_addr)
o_mem_rd_en  out  1  read strobe
o_mem_wr_en  out  4  byte write enables
o_mem_wr_data  out  XLEN  computed new value
o_stall_req  out  1  hold the pipeline
o_amo_result  out  XLEN  old memory value (rd data)
o_amo_write_enable  out  1  single-cycle pulse, result valid
o_misaligned  out  1  single-cycle pulse, address not word aligned
i_lr_valid  in  1  LR.W executing (optional feature)
i_sc_valid  in  1  SC.W executing (optional feature)
i_store_snoop_valid  in  1  ordinary store committing (optional feature)
i_store_snoop_addr  in  XLEN  address of that store (optional feature)
o_sc_success  out  1  SC.W outcome

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All strobes and pulses (o_mem_rd_en, o_mem_wr_en, o_amo_write_enable, o_misaligned) are 0.
  - o_amo_result=0, o_mem_addr=0, o_mem_wr_data=0.
  - The reservation is invalid.
- o_stall_req = (state!=IDLE) | (state==IDLE & i_amo_start). It is combinational, so the stall is seen in the same cycle as the start.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - On i_amo_start, latch funct5, addr and rs2.
  - If addr[1:0]!=0: pulse o_misaligned next cycle, make no memory access, stay in IDLE.
  - Otherwise go to READ.
- READ: o_mem_rd_en=1, o_mem_addr=latched addr. Go to CAPTURE.
- CAPTURE:
  - Register old=i_mem_rd_data.
  - new = f(funct5, old, rs2):
    - SWAP(00001)=rs2; ADD(00000)=old+rs2 mod 2^32.
    - XOR(00100), OR(01000), AND(01100): bitwise.
    - MIN(10000)/MAX(10100): signed comparison.
    - MINU(11000)/MAXU(11100): unsigned comparison.
  - Go to WRITE.
- WRITE:
  - o_mem_wr_en=4'hF, o_mem_wr_data=new.
  - o_amo_result=old; o_amo_write_enable=1 for exactly this cycle.
  - o_stall_req=1 for this cycle. Next state IDLE.
- Reserved funct5 (not listed above, not LR/SC): runs the same sequence, but o_mem_wr_en=0 in WRITE. rd still receives old.
- Latency: start seen in cycle 0 → read in cycle 1 → write and result in cycle 3. The stall deasserts in cycle 4.
- i_amo_start while not in IDLE is ignored: the pipeline is stalled, so EX holds the instruction.
- Reset asserted mid-operation aborts immediately. No partial write is issued afterwards.

Optional Feature:
- Macro: FROST_AMO_LR_RESERVATION_EN.
- Defined: the block owns a reservation register {valid, word addr}.
  - Set on i_lr_valid with i_addr[XLEN-1:2].
  - Cleared by:
    - any SC (i_sc_valid);
    - an AMO WRITE to the same word;
    - an i_store_snoop_valid to the same word.
  - o_sc_success = valid & (i_addr[XLEN-1:2]==stored word), evaluated combinationally while i_sc_valid.
  - If LR and a clearing event occur in the same cycle, LR wins.
- Undefined:
  - No reservation register exists.
  - o_sc_success is tied to 1 (single-hart, interrupt-free configurations).
  - i_lr_valid, i_sc_valid and the snoop inputs are ignored.

Decomposition:
- riscv_pkg:
  - amo_funct5_e enum with the nine encodings above;
  - amo_state_e {IDLE, READ, CAPTURE, WRITE};
  - localparam AMO_LATENCY=3.
- Sub-module amo_alu: purely combinational f(funct5, old, rs2), instantiated once.

Test Plan:
- mem[0x100]=5; AMOADD addr=0x100, rs2=7 → read cycle 1; write 12 with o_mem_wr_en=F in cycle 3; o_amo_result=5 with a 1-cycle pulse; stall high in cycles 0–3.
- mem=0xFFFFFFFF; AMOMIN rs2=1 → stores 0xFFFFFFFF. Same setup with AMOMINU → stores 1. Result is 0xFFFFFFFF in both cases.
- AMOSWAP addr=0x102 → o_misaligned pulse; no rd_en or wr_en; stall only in cycle 0; no o_amo_write_enable.
- Reserved funct5 11111 with mem=0xAA → result 0xAA, o_mem_wr_en stays 0, memory unchanged.
- i_rst_n dropped during CAPTURE → state IDLE, all outputs 0, no write afterwards. A subsequent AMOXOR mem=0xF0, rs2=0xFF stores 0x0F.
- With FROST_AMO_LR_RESERVATION_EN defined:
  - LR 0x200, then snoop store 0x200, then SC 0x200 → o_sc_success=0.
  - LR 0x200, then SC 0x200 → o_sc_success=1.
